structural_mux: RTL and testbench
=================================

Name: structural_mux

Overview:
- Gate-level 2:1 multiplexer: per-bit NOT/AND/OR netlist selecting between two data words.
- Provides a combinational output plus a registered copy and a select-activity counter.
- Used as a basic datapath steering element and as a structural-modelling reference block. The combinational path carries no clock dependency.

Parameters:
- WIDTH, 1, data width of in0/in1/out/out_q in bits (≥1).
- CNT_WIDTH, 8, width of sel_toggles counter (≥1).

Ports:
- clk  input  1  single system clock, rising-edge active.
- rst  input  1  synchronous, active-high reset; sampled on rising clk edge.
- in0  input  WIDTH  data input selected when sel=0.
- in1  input  WIDTH  data input selected when sel=1.
- sel  input  1  select line, shared by all bits.
- out  output  WIDTH  combinational mux result.
- out_q  output  WIDTH  registered mux result, one clk late.
- sel_toggles  output  CNT_WIDTH  count of sel value changes seen at clk edges, saturating.

Behaviour:
- Port order for positional instantiation: in0, in1, sel, out, then clk, rst, out_q, sel_toggles.
  - The first four positions must stay in this order for legacy positional instances.
- Combinational path, per bit i: out[i] = (in0[i] AND NOT sel) OR (in1[i] AND sel).
  - Built from a generate loop of gate primitives: one shared inverter on sel, two AND gates per bit, one OR gate per bit.
  - No behavioural "?:" operator and no always block on this path.
- out is independent of clk and rst: zero-cycle latency, valid after gate delay (zero delay in RTL). Reset does not force out.
- Truth table (WIDTH=1, in0 in1 sel -> out): 000->0, 001->0, 010->0, 011->1, 100->1, 101->0, 110->1, 111->1.
- out_q:
  - On rising clk with rst=1: out_q <= 0.
  - Else out_q <= out as sampled at that edge. Latency exactly 1 cycle.
- sel_toggles:
  - Internal sel_d register captures sel each edge; reset value of both is 0.
  - Increments by 1 on an edge where sel != sel_d and rst=0.
  - Saturates at 2^CNT_WIDTH-1 with no wrap.
- Reset mid-operation:
  - out_q and sel_toggles clear on the first reset edge.
  - The first post-reset edge compares sel against sel_d=0, so sel=1 at that edge counts as one toggle.
- X/Z on sel: out follows gate-level X propagation. No sanitising logic.
- All bits are independent. WIDTH=1 behaves exactly per the truth table.

Test Plan:
- Truth-table sweep, WIDTH=1, rst low: hold {in0,in1,sel}=000 for 50 ns, then step 001,010,011,100,101,110,111 every 10 ns -> out = 0,0,0,1,1,0,1,1 within each step, with no clk needed.
- Registered path: clk 10 ns period; apply in0=1,in1=0,sel=0 -> out_q=1 one edge later; set sel=1 -> out_q=0 after next edge.
- Reset: assert rst for 2 edges with out=1 -> out_q=0 and sel_toggles=0; out remains 1 throughout.
- Toggle counter: after reset, alternate sel each cycle for 5 edges -> sel_toggles=5; hold sel for 3 edges -> stays 5.
- Saturation: CNT_WIDTH=2, toggle sel 6 times -> sel_toggles=3, no wrap.
- Width: WIDTH=8, in0=0xA5, in1=0x3C -> out=0xA5 with sel=0 and out=0x3C with sel=1; out_q matches one cycle later.

Source files
------------

// File: rtl/structural_mux.sv
// Gate-level 2:1 word multiplexer with a registered copy of the result and a
// saturating counter of select-line changes observed at clock edges.
module structural_mux #(
    parameter int WIDTH     = 1,
    parameter int CNT_WIDTH = 8
) (
    input  logic [WIDTH-1:0]     in0,
    input  logic [WIDTH-1:0]     in1,
    input  logic                 sel,
    output wire  [WIDTH-1:0]     out,
    input  logic                 clk,
    input  logic                 rst,
    output logic [WIDTH-1:0]     out_q,
    output logic [CNT_WIDTH-1:0] sel_toggles
);

    wire             sel_n;
    wire [WIDTH-1:0] pick0;
    wire [WIDTH-1:0] pick1;

    // One inverter serves every bit; X on sel propagates through the gates.
    not g_sel_inv (sel_n, sel);

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            and g_and0 (pick0[gi], in0[gi], sel_n);
            and g_and1 (pick1[gi], in1[gi], sel);
            or  g_or   (out[gi], pick0[gi], pick1[gi]);
        end
    endgenerate

    logic [WIDTH-1:0]     out_q_reg;
    logic                 sel_d_reg;
    logic [CNT_WIDTH-1:0] sel_toggles_reg;
    logic [CNT_WIDTH-1:0] sel_toggles_next;

    // Count a change only while the counter has headroom, so it sticks at all-ones.
    always_comb begin
        sel_toggles_next = sel_toggles_reg;
        if ((sel != sel_d_reg) && (sel_toggles_reg != {CNT_WIDTH{1'b1}})) begin
            sel_toggles_next = sel_toggles_reg + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q_reg       <= '0;
            sel_d_reg       <= 1'b0;
            sel_toggles_reg <= '0;
        end else begin
            out_q_reg       <= out;
            sel_d_reg       <= sel;
            sel_toggles_reg <= sel_toggles_next;
        end
    end

    assign out_q       = out_q_reg;
    assign sel_toggles = sel_toggles_reg;

endmodule

// File: tb/tb_structural_mux.sv
// Scoreboard bench for structural_mux: stimulus queues expected values, a
// monitor process samples the DUT outputs and compares.
module tb_structural_mux;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // WIDTH=1, CNT_WIDTH=8
    logic       a0, a1, s1;
    wire        o1;
    logic       oq1;
    logic [7:0] tog1;
    // WIDTH=8, CNT_WIDTH=8
    logic [7:0] b0, b1;
    logic       s8;
    wire  [7:0] o8;
    logic [7:0] oq8;
    logic [7:0] tog8;
    // WIDTH=1, CNT_WIDTH=2
    logic       c0, c1, ss;
    wire        os;
    logic       oqs;
    logic [1:0] togs;

    structural_mux #(.WIDTH(1), .CNT_WIDTH(8)) u1 (
        .in0(a0), .in1(a1), .sel(s1), .out(o1),
        .clk(clk), .rst(rst), .out_q(oq1), .sel_toggles(tog1));
    structural_mux #(.WIDTH(8), .CNT_WIDTH(8)) u8 (
        .in0(b0), .in1(b1), .sel(s8), .out(o8),
        .clk(clk), .rst(rst), .out_q(oq8), .sel_toggles(tog8));
    structural_mux #(.WIDTH(1), .CNT_WIDTH(2)) us (
        .in0(c0), .in1(c1), .sel(ss), .out(os),
        .clk(clk), .rst(rst), .out_q(oqs), .sel_toggles(togs));

    localparam int ID_OUT1  = 0;
    localparam int ID_OUTQ1 = 1;
    localparam int ID_TOG1  = 2;
    localparam int ID_OUT8  = 3;
    localparam int ID_OUTQ8 = 4;
    localparam int ID_TOGS  = 5;

    typedef struct {
        int          id;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    event sample_ev;
    int   chk_cnt  = 0;
    int   pass_cnt = 0;

    task automatic expect_val(input int id, input logic [31:0] exp, input string name);
        exp_t e;
        e.id = id; e.exp = exp; e.name = name;
        sb_q.push_back(e);
        -> sample_ev;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] probe(input int id);
        logic [31:0] v;
        v = '0;
        case (id)
            ID_OUT1:  v = {31'd0, o1};
            ID_OUTQ1: v = {31'd0, oq1};
            ID_TOG1:  v = {24'd0, tog1};
            ID_OUT8:  v = {24'd0, o8};
            ID_OUTQ8: v = {24'd0, oq8};
            ID_TOGS:  v = {30'd0, togs};
            default:  v = 'x;
        endcase
        return v;
    endfunction

    // Monitor: drain everything queued for this sample point.
    initial begin
        forever begin
            @(sample_ev);
            while (sb_q.size() > 0) begin
                exp_t e;
                logic [31:0] act;
                e   = sb_q.pop_front();
                act = probe(e.id);
                chk_cnt++;
                if (act === e.exp) begin
                    pass_cnt++;
                    $display("t=%0t check %s got 0x%0h", $time, e.name, act);
                end else begin
                    $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", e.name, act, e.exp, $time);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", pass_cnt, chk_cnt);
        $fatal(1, "timeout");
    end

    logic [7:0] tt_exp;
    logic [2:0] vec;

    initial begin
        rst = 1'b1;
        a0 = 0; a1 = 0; s1 = 0;
        b0 = '0; b1 = '0; s8 = 0;
        c0 = 0; c1 = 0; ss = 0;
        tt_exp = 8'b1101_1000;

        // Reset state
        tick(); tick();
        expect_val(ID_OUTQ1, 32'd0, "reset_outq1");
        expect_val(ID_TOG1,  32'd0, "reset_tog1");
        expect_val(ID_OUTQ8, 32'd0, "reset_outq8");
        expect_val(ID_TOGS,  32'd0, "reset_togs");
        rst = 1'b0;
        #4;

        // Truth table, combinational only
        for (int v = 0; v < 8; v++) begin
            vec = 3'(v);
            {a0, a1, s1} = vec;
            #3;
            expect_val(ID_OUT1, {31'd0, tt_exp[vec]}, $sformatf("tt_%0d%0d%0d", vec[2], vec[1], vec[0]));
            #7;
        end

        // Registered path
        tick();
        a0 = 1; a1 = 0; s1 = 0;
        tick();
        expect_val(ID_OUTQ1, 32'd1, "outq_sel0");
        s1 = 1;
        #1;
        expect_val(ID_OUT1, 32'd0, "out_sel1");
        expect_val(ID_OUTQ1, 32'd1, "outq_hold");
        tick();
        expect_val(ID_OUTQ1, 32'd0, "outq_sel1");

        // Reset mid-operation with out=1
        a0 = 1; a1 = 1; s1 = 1;
        rst = 1'b1;
        #1;
        expect_val(ID_OUT1, 32'd1, "rst_out_pre");
        for (int k = 0; k < 2; k++) begin
            tick();
            expect_val(ID_OUTQ1, 32'd0, $sformatf("rst_outq_e%0d", k));
            expect_val(ID_TOG1,  32'd0, $sformatf("rst_tog_e%0d", k));
            expect_val(ID_OUT1,  32'd1, $sformatf("rst_out_e%0d", k));
        end
        rst = 1'b0;

        // First post-reset edge with sel=1 counts against sel_d=0
        tick();
        expect_val(ID_TOG1,  32'd1, "tog_first_edge");
        expect_val(ID_OUTQ1, 32'd1, "outq_after_rst");
        for (int k = 0; k < 4; k++) begin
            s1 = ~s1;
            tick();
        end
        expect_val(ID_TOG1, 32'd5, "tog_after5");
        for (int k = 0; k < 3; k++) tick();
        expect_val(ID_TOG1, 32'd5, "tog_hold3");

        // Saturation with CNT_WIDTH=2
        ss = 1; tick();
        ss = 0; tick();
        expect_val(ID_TOGS, 32'd2, "sat_2");
        ss = 1; tick();
        expect_val(ID_TOGS, 32'd3, "sat_3");
        ss = 0; tick();
        ss = 1; tick();
        ss = 0; tick();
        expect_val(ID_TOGS, 32'd3, "sat_6_nowrap");

        // WIDTH=8
        b0 = 8'hA5; b1 = 8'h3C; s8 = 0;
        #1;
        expect_val(ID_OUT8, 32'hA5, "w8_out_sel0");
        tick();
        expect_val(ID_OUTQ8, 32'hA5, "w8_outq_sel0");
        s8 = 1;
        #1;
        expect_val(ID_OUT8,  32'h3C, "w8_out_sel1");
        expect_val(ID_OUTQ8, 32'hA5, "w8_outq_lag");
        tick();
        expect_val(ID_OUTQ8, 32'h3C, "w8_outq_sel1");

        #2;
        if (sb_q.size() != 0) begin
            chk_cnt++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
